// File: rtl/fifo36_pkg.sv
// Field layout of the 36-bit framed FIFO word, shared by the framing logic.
package fifo36_pkg;

    localparam int SOF_BIT = 32;
    localparam int EOF_BIT = 33;
    localparam int OCC_MSB = 35;
    localparam int OCC_LSB = 34;

    typedef logic [35:0] fifo36_word_t;

    // occ is only meaningful on an EOF word; 0 means all four bytes are valid
    function automatic logic [1:0] occ_last_idx(input logic eof, input logic [1:0] occ);
        return (eof && occ != 2'd0) ? occ - 2'd1 : 2'd3;
    endfunction

endpackage

// File: rtl/fifo36_byte_unpacker.sv
// Splits 36-bit framed FIFO words into a byte stream with SOF/EOF and flags framing errors.
// Optional: `define FIFO36_UNPACK_ERRCNT_EN adds a saturating err_count output.
module fifo36_byte_unpacker
    import fifo36_pkg::*;
#(
    parameter bit BIG_ENDIAN  = 1'b1,
    parameter bit DROP_ORPHAN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  fifo36_word_t datain,
    input  logic         src_rdy_i,
    output logic         dst_rdy_o,
    output logic [7:0]   dataout,
    output logic         sof_o,
    output logic         eof_o,
    output logic         src_rdy_o,
    input  logic         dst_rdy_i,
    output logic         frame_err
`ifdef FIFO36_UNPACK_ERRCNT_EN
    ,
    output logic [15:0]  err_count
`endif
);

    logic [31:0] word_q, word_n;
    logic [1:0]  idx_q, idx_n, last_q, last_n, lane_n;
    logic        sofw_q, sofw_n, eofw_q, eofw_n;
    logic        held_n, in_frame_q;
    logic        last_byte, out_xfer, in_xfer, load, err;
    logic        w_sof, w_eof, orphan, drop;
    logic [1:0]  w_occ;

    assign w_sof  = datain[SOF_BIT];
    assign w_eof  = datain[EOF_BIT];
    assign w_occ  = datain[OCC_MSB:OCC_LSB];

    // src_rdy_o doubles as the "word held" flag
    assign last_byte = (idx_q == last_q);
    assign out_xfer  = src_rdy_o & dst_rdy_i;
    assign dst_rdy_o = ~src_rdy_o | (out_xfer & last_byte);
    assign in_xfer   = src_rdy_i & dst_rdy_o;

    assign orphan = ~w_sof & ~in_frame_q;
    assign drop   = orphan & DROP_ORPHAN;
    assign load   = in_xfer & ~drop;
    assign err    = in_xfer & ((w_sof & in_frame_q) | orphan | ((w_occ != 2'd0) & ~w_eof));

    always_comb begin
        held_n = src_rdy_o;
        word_n = word_q;
        idx_n  = idx_q;
        last_n = last_q;
        sofw_n = sofw_q;
        eofw_n = eofw_q;
        if (load) begin
            held_n = 1'b1;
            word_n = datain[31:0];
            idx_n  = 2'd0;
            last_n = occ_last_idx(w_eof, w_occ);
            sofw_n = w_sof;
            eofw_n = w_eof;
        end else if (out_xfer) begin
            if (last_byte) held_n = 1'b0;
            else           idx_n  = idx_q + 2'd1;
        end
    end

    // byte index 0 maps to lane 3 ([31:24]) in big-endian order
    assign lane_n = BIG_ENDIAN ? ~idx_n : idx_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q     <= '0;
            idx_q      <= '0;
            last_q     <= '0;
            sofw_q     <= 1'b0;
            eofw_q     <= 1'b0;
            in_frame_q <= 1'b0;
            src_rdy_o  <= 1'b0;
            dataout    <= '0;
            sof_o      <= 1'b0;
            eof_o      <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            word_q    <= word_n;
            idx_q     <= idx_n;
            last_q    <= last_n;
            sofw_q    <= sofw_n;
            eofw_q    <= eofw_n;
            src_rdy_o <= held_n;
            if (held_n) dataout <= word_n[{lane_n, 3'b000} +: 8];
            sof_o     <= held_n & sofw_n & (idx_n == 2'd0);
            eof_o     <= held_n & eofw_n & (idx_n == last_n);
            frame_err <= err;
            if (in_xfer) begin
                if (w_sof)      in_frame_q <= ~w_eof;
                else if (w_eof) in_frame_q <= 1'b0;
            end
        end
    end

`ifdef FIFO36_UNPACK_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                             err_count <= '0;
        else if (err && err_count != 16'hFFFF)  err_count <= err_count + 16'd1;
    end
`endif

endmodule
